// File: rtl/fifo_sync.sv
// Single-clock FIFO with strobe-qualified writes and reads, registered read data
// (one-cycle latency) and full/empty flags decoded from a registered occupancy count.
module fifo_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come only from registered count, so there is no input-to-output path.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Writes are gated only by full, reads only by empty; at empty a same-cycle
  // read is rejected, so there is no fall-through.
  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  // NOTE: the storage array has no reset; a reset only clears the pointers and
  // count, which makes any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        data_out <= mem[rptr];
        rptr     <= rptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: stimulus pushes expected read data into a queue,
// and an independent monitor pops and compares on every accepted read.
module tb_fifo_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic        ren;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fifo_sync dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .ren      (ren),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    wen     = w;
    ren     = r;
    data_in = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [31:0] expected);
    exp_q.push_back(expected);
    cyc(1'b0, 1'b1, 32'h0);
  endtask

  task automatic flags(input string name, input logic exp_full, input logic exp_empty);
    check({name, "_full"},  {31'b0, full},  {31'b0, exp_full});
    check({name, "_empty"}, {31'b0, empty}, {31'b0, exp_empty});
  endtask

  // Monitor: a read is accepted when ren is high and empty low at the rising edge.
  always @(posedge clk) begin
    logic        fire;
    logic [31:0] exp;
    fire = rst && ren && !empty;
    if (fire) begin
      #1;
      if (exp_q.size() == 0) begin
        check("unexpected_read", data_out, 32'hxxxx_xxxx);
      end else begin
        exp = exp_q.pop_front();
        check("read_data", data_out, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] words [8] = '{32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663,
                             32'h06B97B0D, 32'h46DF998D, 32'hB2C28465, 32'h89375212};
  logic [31:0] w [12]    = '{32'h0, 32'h11110001, 32'h11110002, 32'h11110003,
                             32'h11110004, 32'h11110005, 32'h11110006, 32'h11110007,
                             32'h11110008, 32'h11110009, 32'h1111000A, 32'h1111000B};
  logic [31:0] x [9]     = '{32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003,
                             32'h22220004, 32'h22220005, 32'h22220006, 32'h22220007,
                             32'h22220008};

  initial begin
    rst = 1'b0; wen = 1'b0; ren = 1'b0; data_in = 32'h0;

    // Reset held for two cycles, with a write attempt that must be ignored.
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'hDEADBEEF);
    flags("reset", 1'b0, 1'b1);
    check("reset_data_out", data_out, 32'h0);

    // Three writes, then an asynchronous mid-cycle reset.
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) wr(words[i]);
    flags("pre_async", 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 flags("async_reset", 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1;
    check("async_data_out", data_out, 32'h0);

    // Fill.
    wr(words[0]);
    flags("fill_first", 1'b0, 1'b0);
    for (int i = 1; i < 7; i++) wr(words[i]);
    flags("fill_seven", 1'b0, 1'b0);
    wr(words[7]);
    flags("fill_full", 1'b1, 1'b0);

    // Overflow attempt.
    wr(32'hCAFEBABE);
    flags("overflow", 1'b1, 1'b0);

    // Drain in write order.
    rd(words[0]);
    flags("drain_first", 1'b0, 1'b0);
    for (int i = 1; i < 7; i++) rd(words[i]);
    flags("drain_seven", 1'b0, 1'b0);
    rd(words[7]);
    flags("drain_empty", 1'b0, 1'b1);

    // Underflow attempt: nothing changes.
    cyc(1'b0, 1'b1, 32'h0);
    check("underflow_data_out", data_out, 32'h89375212);
    flags("underflow", 1'b0, 1'b1);
    wr(32'hA5A50001);
    rd(32'hA5A50001);
    flags("post_underflow", 1'b0, 1'b1);

    // Wrap: write 5, read 3, write 6 -> full, then 8 reads in order.
    for (int i = 1; i <= 5; i++) wr(w[i]);
    for (int i = 1; i <= 3; i++) rd(w[i]);
    for (int i = 6; i <= 11; i++) wr(w[i]);
    flags("wrap_full", 1'b1, 1'b0);
    for (int i = 4; i <= 11; i++) rd(w[i]);
    flags("wrap_drained", 1'b0, 1'b1);

    // Simultaneous write/read at count 4: count stays 4, so 4 more writes fill it.
    for (int i = 0; i < 4; i++) wr(x[i]);
    exp_q.push_back(x[0]);
    cyc(1'b1, 1'b1, x[4]);
    flags("simul_mid", 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) wr(x[i]);
    flags("simul_mid_seven", 1'b0, 1'b0);
    wr(x[8]);
    flags("simul_mid_full", 1'b1, 1'b0);

    // Simultaneous at full: read accepted, write rejected, count 7.
    exp_q.push_back(x[1]);
    cyc(1'b1, 1'b1, 32'h33333333);
    flags("simul_full", 1'b0, 1'b0);
    wr(32'h44444444);
    flags("refill", 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) rd(x[i]);
    rd(32'h44444444);
    flags("simul_drained", 1'b0, 1'b1);

    // Simultaneous at empty: write accepted, read rejected, data_out held.
    cyc(1'b1, 1'b1, 32'h55555555);
    check("simul_empty_data_out", data_out, 32'h44444444);
    flags("simul_empty", 1'b0, 1'b0);
    rd(32'h55555555);
    flags("simul_empty_drain", 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_left", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Synchronous single-clock first-in/first-out buffer, 32 bits wide and 8 entries deep by default. Used as a rate-decoupling queue between a producer and a consumer in the same clock domain. Writes and reads are strobe-qualified. Full and empty flags provide overflow and underflow protection. Read data is registered, with one-cycle latency.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, log2(DEPTH) = 3, pointer index width; derived, not overridden.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset asserted); deassertion is sampled synchronously by the design's state.
- wen, input, 1, write enable; a word is written on a rising edge where wen=1 and full=0.
- ren, input, 1, read enable; a word is popped on a rising edge where ren=1 and empty=0.
- data_in, input, DATA_WIDTH, write data, sampled on the accepting edge.
- data_out, output, DATA_WIDTH, registered read data.
- full, output, 1, high when the FIFO holds DEPTH words.
- empty, output, 1, high when the FIFO holds 0 words.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. Write pointer, read pointer and occupancy count (ADDR_WIDTH+1 bits, range 0..DEPTH) are held in registers.
- Reset (rst=0, asynchronous, immediate):
  - pointers = 0, count = 0, data_out = 0, empty = 1, full = 0.
  - Array contents are not cleared.
  - Reset asserted mid-operation discards all stored data.
  - wen and ren are ignored while reset is asserted.
- Write accept: wr_ok = wen & ~full.
  - mem[wptr] <= data_in.
  - wptr increments modulo DEPTH; it wraps from DEPTH-1 to 0.
- Read accept: rd_ok = ren & ~empty.
  - data_out <= mem[rptr] on that edge; data is valid immediately after the edge, so latency is one clock from the ren-sampling edge.
  - rptr increments modulo DEPTH.
- data_out holds its last value when no read is accepted, including on underflow attempts.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither occur.
- Flags:
  - full = (count == DEPTH); empty = (count == 0).
  - Both are decoded from registered count, so they change on the same edge as the count.
- Overflow: wen while full is ignored. Memory, pointers, count and data_out are unchanged; no error output.
- Underflow: ren while empty is ignored. All state is unchanged.
- Simultaneous wen and ren:
  - Neither full nor empty: both accepted, count unchanged, data_out gets the oldest word.
  - Full: read accepted, write rejected (wen is gated by full only). Count becomes DEPTH-1.
  - Empty: write accepted, read rejected; no fall-through. data_out is unchanged and empty deasserts on that edge.
- Ordering: words are read out in exactly the order they were accepted, across any number of pointer wraps.
- No combinational path from any input to data_out, full or empty.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wen=ren=0 -> empty=1, full=0, data_out=0. Assert rst=0 asynchronously mid-cycle after 3 writes -> count 0, empty=1 immediately, before the next edge.
- Fill: release reset, write 8 words (e.g. 0x12153524, 0xC0895E81, ... sequence) one per pulse -> empty falls after the 1st accepted edge; full rises on the edge accepting the 8th word.
- Overflow: with full=1, pulse wen with data_in=0xCAFEBABE -> rejected; full stays 1, count 8; subsequent reads never return 0xCAFEBABE.
- Drain: 8 single-cycle ren pulses -> data_out, sampled after each accepting edge, equals the 8 written words in write order. full drops after the 1st read; empty rises after the 8th.
- Underflow: ren while empty -> data_out keeps the 8th word; empty stays 1; pointers unchanged (the next write/read pair returns the new word).
- Wrap and simultaneity:
  - Write 5, read 3, write 6 -> full=1 with pointers wrapped; reads return 8 words in order.
  - wen=ren=1 at count=4 -> count stays 4.
  - wen=ren=1 at full -> count becomes 7.
  - wen=ren=1 at empty -> count becomes 1, data_out unchanged.
